// File: rtl/imem_access_ctrl_if.sv
// Bus bundle between imem_access_ctrl, the fetch stage, the program loader and the
// instruction memory. The controller uses the slave modport; the environment uses master.
interface imem_access_ctrl_if #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned FETCH_BYTES = 10
);
    localparam int unsigned AddrW = $clog2(MEM_BYTES);
    localparam int unsigned DataW = FETCH_BYTES * 8;

    logic             f_req_i;
    logic [63:0]      f_addr_i;
    logic             f_stall_o;
    logic             f_valid_o;
    logic [DataW-1:0] f_rdata_o;
    logic             f_error_o;

    logic             ld_start_i;
    logic             ld_valid_i;
    logic [63:0]      ld_addr_i;
    logic [7:0]       ld_data_i;
    logic             ld_ready_o;
    logic             ld_done_i;
    logic [10:0]      ld_count_o;
    logic             ld_err_o;
    logic             busy_o;

    logic [63:0]      mem_raddr_o;
    logic [DataW-1:0] mem_rdata_i;
    logic             mem_error_i;
    logic             mem_we_o;
    logic [AddrW-1:0] mem_waddr_o;
    logic [7:0]       mem_wdata_o;

    modport slave (
        input  f_req_i, f_addr_i, ld_start_i, ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
        input  mem_rdata_i, mem_error_i,
        output f_stall_o, f_valid_o, f_rdata_o, f_error_o, ld_ready_o, ld_count_o, ld_err_o,
        output busy_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );

    modport master (
        output f_req_i, f_addr_i, ld_start_i, ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
        output mem_rdata_i, mem_error_i,
        input  f_stall_o, f_valid_o, f_rdata_o, f_error_o, ld_ready_o, ld_count_o, ld_err_o,
        input  busy_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );
endinterface

// File: rtl/imem_access_ctrl.sv
// Shares the Y86 instruction memory between fetch (10-byte reads) and a byte loader;
// fetch is stalled while loading and for one drain cycle afterwards.
module imem_access_ctrl #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned FETCH_BYTES = 10
) (
    input logic             clk_i,
    input logic             rst_i,
    imem_access_ctrl_if.slave bus
);
    localparam int unsigned AddrW = $clog2(MEM_BYTES);
    localparam int unsigned DataW = FETCH_BYTES * 8;

    typedef enum logic [1:0] {StRun, StLoad, StDrain} state_e;

    state_e           state_q, state_d;
    logic             f_valid_q, f_valid_d;
    logic [DataW-1:0] f_rdata_q, f_rdata_d;
    logic             f_error_q, f_error_d;
    logic [10:0]      ld_count_q, ld_count_d;
    logic             ld_err_q, ld_err_d;
    logic             ld_in_range;

    assign ld_in_range = bus.ld_addr_i < 64'(MEM_BYTES);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            f_valid_q  <= 1'b0;
            f_rdata_q  <= '0;
            f_error_q  <= 1'b0;
            ld_count_q <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_valid_q  <= f_valid_d;
            f_rdata_q  <= f_rdata_d;
            f_error_q  <= f_error_d;
            ld_count_q <= ld_count_d;
            ld_err_q   <= ld_err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        f_valid_d       = 1'b0;
        f_rdata_d       = f_rdata_q;
        f_error_d       = f_error_q;
        ld_count_d      = ld_count_q;
        ld_err_d        = ld_err_q;
        bus.f_stall_o   = 1'b1;
        bus.ld_ready_o  = 1'b0;
        bus.mem_raddr_o = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_waddr_o = '0;
        bus.mem_wdata_o = '0;

        unique case (state_q)
            StRun: begin
                bus.f_stall_o   = 1'b0;
                bus.mem_raddr_o = bus.f_addr_i;
                if (bus.f_req_i) begin
                    f_valid_d = 1'b1;
                    f_rdata_d = bus.mem_rdata_i;
                    f_error_d = bus.mem_error_i;
                end
                if (bus.ld_start_i) begin
                    state_d    = StLoad;
                    ld_count_d = '0;
                    ld_err_d   = 1'b0;
                end
            end
            StLoad: begin
                bus.ld_ready_o  = 1'b1;
                bus.mem_waddr_o = bus.ld_addr_i[AddrW-1:0];
                bus.mem_wdata_o = bus.ld_data_i;
                if (bus.ld_valid_i) begin
                    if (ld_count_q != 11'h7ff) begin
                        ld_count_d = ld_count_q + 11'd1;
                    end
                    // A byte offered while reset is asserted must not reach memory.
                    if (ld_in_range) begin
                        bus.mem_we_o = !rst_i;
                    end else begin
                        ld_err_d = 1'b1;
                    end
                end
                if (bus.ld_done_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    assign bus.f_valid_o  = f_valid_q;
    assign bus.f_rdata_o  = f_rdata_q;
    assign bus.f_error_o  = f_error_q;
    assign bus.ld_count_o = ld_count_q;
    assign bus.ld_err_o   = ld_err_q;
    assign bus.busy_o     = (state_q != StRun);
endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a behavioural memory and a reference model
// checked every cycle, plus literal expectations at key points.
module tb_imem_access_ctrl;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    imem_access_ctrl_if #(.MEM_BYTES(1024), .FETCH_BYTES(10)) bus ();

    imem_access_ctrl #(.MEM_BYTES(1024), .FETCH_BYTES(10)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    // Model state: 0 = run, 1 = load, 2 = drain.
    int          e_state;
    logic        e_valid;
    logic [79:0] e_rdata;
    logic        e_error;
    int          e_count;
    logic        e_err;

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] head;
        head = 32'h0001F130;
        if (i < 4) return head[i*8 +: 8];
        return 8'(i * 7 + 3);
    endfunction

    // Reads starting past 1016 come back as all zero; bytes past the end read as zero.
    function automatic logic [79:0] ref_read(input logic [63:0] a);
        logic [79:0] r;
        r = '0;
        if (a < 64'd1017) begin
            for (int i = 0; i < 10; i++) begin
                if (a + 64'(i) < 64'd1024) r[i*8 +: 8] = ref_mem[int'(a) + i];
            end
        end
        return r;
    endfunction

    always_comb begin
        bus.mem_rdata_i = '0;
        bus.mem_error_i = (bus.mem_raddr_o >= 64'd1024);
        if (bus.mem_raddr_o < 64'd1017) begin
            for (int i = 0; i < 10; i++) begin
                if (bus.mem_raddr_o + 64'(i) < 64'd1024)
                    bus.mem_rdata_i[i*8 +: 8] = mem[int'(bus.mem_raddr_o[9:0]) + i];
            end
        end
    end

    // Memory write port and reference model, both advanced on the rising edge.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = init_byte(i);
            ref_mem[i] = init_byte(i);
        end
        forever begin
            @(posedge clk);
            if (bus.mem_we_o) mem[bus.mem_waddr_o] = bus.mem_wdata_o;
            if (rst) begin
                e_state = 0;
                e_valid = 1'b0;
                e_rdata = '0;
                e_error = 1'b0;
                e_count = 0;
                e_err   = 1'b0;
            end else if (e_state == 0) begin
                e_valid = bus.f_req_i;
                if (bus.f_req_i) begin
                    e_rdata = ref_read(bus.f_addr_i);
                    e_error = (bus.f_addr_i >= 64'd1024);
                end
                if (bus.ld_start_i) begin
                    e_state = 1;
                    e_count = 0;
                    e_err   = 1'b0;
                end
            end else if (e_state == 1) begin
                e_valid = 1'b0;
                if (bus.ld_valid_i) begin
                    if (e_count < 2047) e_count++;
                    if (bus.ld_addr_i < 64'd1024) ref_mem[int'(bus.ld_addr_i)] = bus.ld_data_i;
                    else e_err = 1'b1;
                end
                if (bus.ld_done_i) e_state = 2;
            end else begin
                e_valid = 1'b0;
                e_state = 0;
            end
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic run, load, we;
        run  = (e_state == 0);
        load = (e_state == 1);
        we   = load && bus.ld_valid_i && (bus.ld_addr_i < 64'd1024) && !rst;
        check("f_stall", 80'(bus.f_stall_o), 80'(!run));
        check("ld_ready", 80'(bus.ld_ready_o), 80'(load));
        check("busy", 80'(bus.busy_o), 80'(!run));
        check("mem_raddr", 80'(bus.mem_raddr_o), run ? 80'(bus.f_addr_i) : 80'd0);
        check("mem_we", 80'(bus.mem_we_o), 80'(we));
        if (we) begin
            check("mem_waddr", 80'(bus.mem_waddr_o), 80'(bus.ld_addr_i[9:0]));
            check("mem_wdata", 80'(bus.mem_wdata_o), 80'(bus.ld_data_i));
        end
        check("f_valid", 80'(bus.f_valid_o), 80'(e_valid));
        check("f_rdata", bus.f_rdata_o, e_rdata);
        check("f_error", 80'(bus.f_error_o), 80'(e_error));
        check("ld_count", 80'(bus.ld_count_o), 80'(e_count));
        check("ld_err", 80'(bus.ld_err_o), 80'(e_err));
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.f_req_i    = 1'b0;
        bus.f_addr_i   = '0;
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_addr_i  = '0;
        bus.ld_data_i  = '0;
        bus.ld_done_i  = 1'b0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        check("rst_valid", 80'(bus.f_valid_o), 80'd0);
        check("rst_busy", 80'(bus.busy_o), 80'd0);
        check("rst_count", 80'(bus.ld_count_o), 80'd0);

        // Fetch at 0 and the address boundaries.
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 64'd0;
        tick();
        check("fetch0_valid", 80'(bus.f_valid_o), 80'd1);
        check("fetch0_data", 80'(bus.f_rdata_o[15:0]), 80'h F130);
        check("fetch0_err", 80'(bus.f_error_o), 80'd0);
        bus.f_addr_i = 64'd1016;
        tick();
        check("a1016_byte0", 80'(bus.f_rdata_o[7:0]), 80'h CB);
        check("a1016_tail", 80'(bus.f_rdata_o[79:64]), 80'd0);
        check("a1016_err", 80'(bus.f_error_o), 80'd0);
        bus.f_addr_i = 64'd1020;
        tick();
        check("a1020_data", bus.f_rdata_o, 80'd0);
        check("a1020_err", 80'(bus.f_error_o), 80'd0);
        bus.f_addr_i = 64'd2000;
        tick();
        check("a2000_data", bus.f_rdata_o, 80'd0);
        check("a2000_err", 80'(bus.f_error_o), 80'd1);
        bus.f_req_i = 1'b0;
        tick();
        check("idle_valid", 80'(bus.f_valid_o), 80'd0);

        // Load with fetch held requesting address 10 throughout.
        bus.f_req_i    = 1'b1;
        bus.f_addr_i   = 64'd10;
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        check("load_busy", 80'(bus.busy_o), 80'd1);
        check("load_stall", 80'(bus.f_stall_o), 80'd1);
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = 64'd10;
        bus.ld_data_i  = 8'h40;
        tick();
        bus.ld_addr_i  = 64'd11;
        bus.ld_data_i  = 8'h12;
        tick();
        bus.ld_addr_i  = 64'd12;
        bus.ld_data_i  = 8'h10;
        bus.ld_done_i  = 1'b1;
        tick();
        bus.ld_valid_i = 1'b0;
        bus.ld_done_i  = 1'b0;
        check("drain_busy", 80'(bus.busy_o), 80'd1);
        check("load_count", 80'(bus.ld_count_o), 80'd3);
        tick();
        check("run_busy", 80'(bus.busy_o), 80'd0);
        tick();
        check("post_valid", 80'(bus.f_valid_o), 80'd1);
        check("post_data", 80'(bus.f_rdata_o[23:0]), 80'h 101240);
        bus.f_req_i = 1'b0;
        tick();

        // Out-of-range loader byte, then one good byte.
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = 64'd1024;
        bus.ld_data_i  = 8'h55;
        #1;
        check("oor_we", 80'(bus.mem_we_o), 80'd0);
        tick();
        check("oor_err", 80'(bus.ld_err_o), 80'd1);
        check("oor_count", 80'(bus.ld_count_o), 80'd1);
        bus.ld_addr_i  = 64'd20;
        bus.ld_data_i  = 8'h77;
        bus.ld_done_i  = 1'b1;
        tick();
        bus.ld_valid_i = 1'b0;
        bus.ld_done_i  = 1'b0;
        tick();
        tick();
        check("hold_err", 80'(bus.ld_err_o), 80'd1);
        check("hold_count", 80'(bus.ld_count_o), 80'd2);

        // Reset in the middle of a load.
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = 64'd30;
        bus.ld_data_i  = 8'h11;
        tick();
        bus.ld_addr_i  = 64'd5;
        bus.ld_data_i  = 8'hEE;
        rst            = 1'b1;
        #1;
        check("rst_we", 80'(bus.mem_we_o), 80'd0);
        tick();
        rst            = 1'b0;
        bus.ld_valid_i = 1'b0;
        check("mrst_busy", 80'(bus.busy_o), 80'd0);
        check("mrst_count", 80'(bus.ld_count_o), 80'd0);
        check("mrst_mem5", 80'(mem[5]), 80'h26);
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 64'd28;
        tick();
        check("mrst_byte30", 80'(bus.f_rdata_o[23:16]), 80'h11);
        bus.f_req_i = 1'b0;

        // Loader byte count saturates at 2047.
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b1;
        for (int i = 0; i < 2050; i++) begin
            bus.ld_addr_i = 64'(900 + (i % 50));
            bus.ld_data_i = 8'(i);
            tick();
        end
        bus.ld_valid_i = 1'b0;
        bus.ld_done_i  = 1'b1;
        tick();
        bus.ld_done_i  = 1'b0;
        check("sat_count", 80'(bus.ld_count_o), 80'd2047);
        tick();
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 64'd940;
        tick();
        bus.f_req_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_access_ctrl.md
# imem_access_ctrl

Sequencing and arbitration controller for the byte-addressed Y86 instruction memory. It shares the memory between the pipeline fetch stage (10-byte instruction reads) and a program loader (byte writes). It stalls fetch while a program image is loaded, then drains before fetch resumes. It sits between the fetch stage/loader and the memory, and drives the memory read address and the memory's byte write port.

## Interface
- MEM_BYTES, 1024: instruction memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- FETCH_BYTES, 10: bytes per fetch word.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- f_req_i  in  1  fetch request.
- f_addr_i  in  64  fetch byte address (PC).
- f_stall_o  out  1  fetch must hold its request; this cycle's request is not accepted.
- f_valid_o  out  1  f_rdata_o and f_error_o are valid this cycle.
- f_rdata_o  out  80  fetched bytes; byte at f_addr_i in [7:0].
- f_error_o  out  1  captured memory error for the returned fetch.
- ld_start_i  in  1  pulse; request entry to load mode.
- ld_valid_i  in  1  loader byte valid.
- ld_addr_i  in  64  loader byte address.
- ld_data_i  in  8  loader byte.
- ld_ready_o  out  1  byte accepted when ld_valid_i && ld_ready_o.
- ld_done_i  in  1  pulse; last byte sent, leave load mode.
- ld_count_o  out  11  bytes accepted in the current or last load.
- ld_err_o  out  1  sticky; an out-of-range loader address was seen.
- busy_o  out  1  controller is not in RUN.
- mem_raddr_o  out  64  memory read address.
- mem_rdata_i  in  80  memory read data (combinational).
- mem_error_i  in  1  memory address error (combinational).
- mem_we_o  out  1  memory byte write enable.
- mem_waddr_o  out  10  memory write address.
- mem_wdata_o  out  8  memory write byte.

## Operation
- Three states: RUN, LOAD, DRAIN. Reset state is RUN.
- RUN
  - f_stall_o=0, ld_ready_o=0, mem_raddr_o=f_addr_i (combinational).
  - If f_req_i: capture mem_rdata_i into f_rdata_o and mem_error_i into f_error_o, and set f_valid_o for the next cycle. Otherwise f_valid_o=0 next cycle.
  - If ld_start_i: go to LOAD next cycle, clear ld_count_o and ld_err_o. A fetch request in the same cycle is still served.
- LOAD
  - f_stall_o=1, ld_ready_o=1, f_valid_o=0, mem_raddr_o=0.
  - On an accepted byte, ld_count_o increments, saturating at 2047.
  - If ld_addr_i < MEM_BYTES: mem_we_o=1, mem_waddr_o=ld_addr_i[9:0], mem_wdata_o=ld_data_i, all combinational, and the write commits on that edge.
  - Otherwise mem_we_o=0 and ld_err_o sets. The byte is still counted.
  - ld_done_i goes to DRAIN. A byte accepted in the same cycle as ld_done_i is written.
  - ld_start_i is ignored in LOAD.
- DRAIN: lasts exactly one cycle with f_stall_o=1, ld_ready_o=0, mem_we_o=0, then goes to RUN.
- busy_o=1 in LOAD and DRAIN.
- mem_we_o is 0 in every state except LOAD.
- f_rdata_o and f_error_o hold their last captured values when f_valid_o=0.
- ld_count_o and ld_err_o hold after the load until the next ld_start_i.

## Timing
- Reset values: state RUN, f_valid_o=0, f_rdata_o=0, f_error_o=0, ld_count_o=0, ld_err_o=0, mem_we_o=0, f_stall_o=0, ld_ready_o=0, busy_o=0.
- Fetch latency is 1 cycle: request in cycle N, f_valid_o in cycle N+1. Throughput is one fetch per cycle in RUN.
- ld_start_i in cycle N: LOAD in N+1. The first byte can be accepted in N+1.
- ld_done_i in cycle M: DRAIN in M+1, RUN in M+2. The first fetch accepted in M+2 returns in M+3 and sees all loaded bytes.
- Address boundaries are taken from the memory unchanged. f_addr_i 1017..1023 returns zero data with f_error_o=0. f_addr_i >= 1024 returns zero data with f_error_o=1.
- Reset mid-LOAD: next cycle is RUN. Writes stop immediately; a byte accepted in the reset cycle is not written. ld_count_o and ld_err_o clear.
- ld_valid_i in RUN or DRAIN: ld_ready_o=0 and nothing is written.

## Test plan
- Reset then fetch: assert rst_i 2 cycles, then f_req_i with addr 0 on a memory holding 30 F1 01 00.. -> next cycle f_valid_o=1, f_rdata_o[15:0]=16'hF130, f_error_o=0.
- Load sequence: ld_start_i, then bytes 40,12,10 to addresses 10,11,12, then ld_done_i -> ld_count_o=3, busy_o drops 2 cycles after ld_done_i, and a fetch at 10 returns low bytes 10 12 40.
- Out-of-range load: a byte to address 1024 -> mem_we_o=0, ld_err_o=1, ld_count_o increments.
- Stall: f_req_i held through LOAD/DRAIN -> f_stall_o=1 and f_valid_o=0 throughout; the first valid fetch returns 1 cycle after RUN resumes.
- Fetch error boundaries: addr 1016 -> data with f_error_o=0; addr 1020 -> zero data, f_error_o=0; addr 2000 -> zero data, f_error_o=1.
- Reset mid-load: rst_i while ld_valid_i=1 to address 5 -> memory byte 5 unchanged, state RUN, ld_count_o=0.
